// File: rtl/fp_issue_queue_pkg.sv
// Shared widths, constants and queue-entry layout for the FP issue queue.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package fp_issue_queue_pkg;

    localparam int MicOperateCode = 8;
    localparam int InstAddrBus    = 32;
    localparam int ArchRegBUs     = 5;
    localparam int FaluWidth      = 32;
    localparam int FaluOpWidth    = 2 * FaluWidth;

    localparam logic [FaluOpWidth-1:0] FP_ZERO = '0;

    // One waiting micro-op with its two source operands.
    typedef struct packed {
        logic                      valid;
        logic [MicOperateCode-1:0] micop;
        logic [InstAddrBus-1:0]    pc;
        logic                      predict;
        logic [FaluWidth-1:0]      offset;
        logic [ArchRegBUs-1:0]     src1_addr;
        logic                      src1_rdy;
        logic [FaluOpWidth-1:0]    src1_dat;
        logic [ArchRegBUs-1:0]     src2_addr;
        logic                      src2_rdy;
        logic [FaluOpWidth-1:0]    src2_dat;
        logic [ArchRegBUs-1:0]     rd;
    } iq_entry_t;

    // Capture a writeback broadcast into any still-pending source of a valid entry.
    function automatic iq_entry_t iq_wakeup(
        input iq_entry_t              e,
        input logic                   wb_vld,
        input logic [ArchRegBUs-1:0]  wb_addr,
        input logic [FaluOpWidth-1:0] wb_dat
    );
        iq_entry_t r;
        r = e;
        if (e.valid && wb_vld) begin
            if (!e.src1_rdy && (e.src1_addr == wb_addr)) begin
                r.src1_rdy = 1'b1;
                r.src1_dat = wb_dat;
            end
            if (!e.src2_rdy && (e.src2_addr == wb_addr)) begin
                r.src2_rdy = 1'b1;
                r.src2_dat = wb_dat;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_iq_select.sv
// Oldest-ready picker: lowest set bit of the ready vector wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module fp_iq_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [DEPTH-1:0] ReadyVec,
    output logic             SelValid,
    output logic [IDX_W-1:0] SelIdx
);

    // Scan from the youngest slot down so the oldest ready slot is the last writer.
    always_comb begin
        SelValid = |ReadyVec;
        SelIdx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ReadyVec[i]) begin
                SelIdx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fp_issue_queue.sv
// Age-ordered FP issue queue: holds micro-ops until both operands arrive, issues oldest ready.
// Latency: dispatch-with-operands to registered issue slot is 2 edges; wakeup to issue is 2 edges.
// Backpressure: InReady drops only when full; FaluStall freezes the issue slot and selection.
module fp_issue_queue
    import fp_issue_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WIDTH_FALU = FaluWidth,
    parameter int MICOP_W    = MicOperateCode,
    parameter int ADDR_W     = InstAddrBus,
    parameter int AREG_W     = ArchRegBUs
) (
    input  logic                    Clk,
    input  logic                    Rest,
    input  logic                    Flush,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [MICOP_W-1:0]      InMicOp,
    input  logic [ADDR_W-1:0]       InInstAddr,
    input  logic                    InPredict,
    input  logic [WIDTH_FALU-1:0]   InJumpOffset,
    input  logic [AREG_W-1:0]       InSrc1Addr,
    input  logic                    InSrc1Rdy,
    input  logic [2*WIDTH_FALU-1:0] InSrc1Data,
    input  logic [AREG_W-1:0]       InSrc2Addr,
    input  logic                    InSrc2Rdy,
    input  logic [2*WIDTH_FALU-1:0] InSrc2Data,
    input  logic [AREG_W-1:0]       InRdAddr,
    input  logic                    WbAble,
    input  logic [AREG_W-1:0]       WbRdAddr,
    input  logic [2*WIDTH_FALU-1:0] WbRdData,
    input  logic                    FaluStall,
    input  logic [WIDTH_FALU-1:0]   Fcsr0Data,
    output logic                    IssValid,
    output logic [MICOP_W-1:0]      IssMicOp,
    output logic [ADDR_W-1:0]       IssInstAddr,
    output logic                    IssPredict,
    output logic [WIDTH_FALU-1:0]   IssJumpOffset,
    output logic [2*WIDTH_FALU-1:0] IssSrc1Data,
    output logic [2*WIDTH_FALU-1:0] IssSrc2Data,
    output logic [AREG_W-1:0]       IssRdAddr,
    output logic [WIDTH_FALU-1:0]   IssFcsr0
);

    // Entry layout comes from the package, so the width parameters must keep their defaults.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    iq_entry_t              ent_q [DEPTH];
    iq_entry_t              ent_d [DEPTH];
    iq_entry_t              woke  [DEPTH+1];
    iq_entry_t              new_ent;
    logic [CNT_W-1:0]       cnt_q, cnt_d, enq_idx;
    logic [DEPTH-1:0]       rdy_vec;
    logic                   sel_vld;
    logic [IDX_W-1:0]       sel_idx;
    logic                   do_enq, do_iss;

    logic [MICOP_W-1:0]      sel_micop;
    logic [ADDR_W-1:0]       sel_pc;
    logic                    sel_pred;
    logic [WIDTH_FALU-1:0]   sel_off;
    logic [2*WIDTH_FALU-1:0] sel_s1, sel_s2;
    logic [AREG_W-1:0]       sel_rd;

    logic                    iss_vld_q;
    logic [MICOP_W-1:0]      iss_micop_q;
    logic [ADDR_W-1:0]       iss_pc_q;
    logic                    iss_pred_q;
    logic [WIDTH_FALU-1:0]   iss_off_q;
    logic [2*WIDTH_FALU-1:0] iss_s1_q, iss_s2_q;
    logic [AREG_W-1:0]       iss_rd_q;
    logic [WIDTH_FALU-1:0]   iss_fcsr_q;

    // Full check looks at the occupancy only, never at same-cycle issue or InValid.
    assign InReady = (cnt_q != CNT_W'(DEPTH));
    assign do_enq  = InValid & InReady & ~Flush;
    assign do_iss  = sel_vld & ~FaluStall;

    // Ready vector is taken from start-of-cycle state; a wakeup this cycle is picked next cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
        end
    end

    fp_iq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .ReadyVec (rdy_vec),
        .SelValid (sel_vld),
        .SelIdx   (sel_idx)
    );

    // Mux out the selected entry's payload fields.
    always_comb begin
        sel_micop = ent_q[0].micop;
        sel_pc    = ent_q[0].pc;
        sel_pred  = ent_q[0].predict;
        sel_off   = ent_q[0].offset;
        sel_s1    = ent_q[0].src1_dat;
        sel_s2    = ent_q[0].src2_dat;
        sel_rd    = ent_q[0].rd;
        for (int i = 1; i < DEPTH; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_micop = ent_q[i].micop;
                sel_pc    = ent_q[i].pc;
                sel_pred  = ent_q[i].predict;
                sel_off   = ent_q[i].offset;
                sel_s1    = ent_q[i].src1_dat;
                sel_s2    = ent_q[i].src2_dat;
                sel_rd    = ent_q[i].rd;
            end
        end
    end

    // Build the arriving entry; a broadcast hitting a pending source is captured on the way in.
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.micop     = InMicOp;
        new_ent.pc        = InInstAddr;
        new_ent.predict   = InPredict;
        new_ent.offset    = InJumpOffset;
        new_ent.src1_addr = InSrc1Addr;
        new_ent.src1_rdy  = InSrc1Rdy;
        new_ent.src1_dat  = InSrc1Rdy ? InSrc1Data : FP_ZERO;
        new_ent.src2_addr = InSrc2Addr;
        new_ent.src2_rdy  = InSrc2Rdy;
        new_ent.src2_dat  = InSrc2Rdy ? InSrc2Data : FP_ZERO;
        new_ent.rd        = InRdAddr;
        new_ent           = iq_wakeup(new_ent, WbAble, WbRdAddr, WbRdData);
    end

    // Next queue image: wake every entry, compact over the issued slot, drop in the arrival; flush wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = iq_wakeup(ent_q[i], WbAble, WbRdAddr, WbRdData);
        end
        woke[DEPTH] = '0;
        enq_idx = do_iss ? (cnt_q - CNT_W'(1)) : cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_iss && (IDX_W'(i) >= sel_idx)) begin
                ent_d[i] = woke[i+1];
            end else begin
                ent_d[i] = woke[i];
            end
            if (do_enq && (enq_idx == CNT_W'(i))) begin
                ent_d[i] = new_ent;
            end
            if (Flush) begin
                ent_d[i] = '0;
            end
        end
        cnt_d = cnt_q;
        if (Flush) begin
            cnt_d = '0;
        end else if (do_enq && !do_iss) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_enq && do_iss) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Issue slot: loads the pick when the ALU accepts, empties when nothing is ready, holds on stall.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            iss_vld_q   <= 1'b0;
            iss_micop_q <= '0;
            iss_pc_q    <= '0;
            iss_pred_q  <= 1'b0;
            iss_off_q   <= '0;
            iss_s1_q    <= FP_ZERO;
            iss_s2_q    <= FP_ZERO;
            iss_rd_q    <= '0;
            iss_fcsr_q  <= '0;
        end else if (Flush) begin
            iss_vld_q <= 1'b0;
        end else if (!FaluStall) begin
            iss_vld_q <= sel_vld;
            if (sel_vld) begin
                iss_micop_q <= sel_micop;
                iss_pc_q    <= sel_pc;
                iss_pred_q  <= sel_pred;
                iss_off_q   <= sel_off;
                iss_s1_q    <= sel_s1;
                iss_s2_q    <= sel_s2;
                iss_rd_q    <= sel_rd;
                iss_fcsr_q  <= Fcsr0Data;
            end
        end
    end

    assign IssValid      = iss_vld_q;
    assign IssMicOp      = iss_micop_q;
    assign IssInstAddr   = iss_pc_q;
    assign IssPredict    = iss_pred_q;
    assign IssJumpOffset = iss_off_q;
    assign IssSrc1Data   = iss_s1_q;
    assign IssSrc2Data   = iss_s2_q;
    assign IssRdAddr     = iss_rd_q;
    assign IssFcsr0      = iss_fcsr_q;

endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed table-driven bench for fp_issue_queue plus hand sequences for reset.
// Latency: each vector is driven at negedge and checked 1 time unit after the next posedge.
// Backpressure: FaluStall and full-queue InReady are exercised through the vector table.
module tb_fp_issue_queue;

    localparam logic [63:0] F1 = 64'h0000_0000_3F80_0000;
    localparam logic [63:0] F2 = 64'h0000_0000_4000_0000;
    localparam logic [63:0] F3 = 64'h0000_0000_4040_0000;
    localparam logic [63:0] Z  = 64'h0;
    localparam logic        Y  = 1'b1;
    localparam logic        N  = 1'b0;

    logic        Clk, Rest, Flush, InValid, InReady, InPredict;
    logic [7:0]  InMicOp, IssMicOp;
    logic [31:0] InInstAddr, InJumpOffset, Fcsr0Data, IssInstAddr, IssJumpOffset, IssFcsr0;
    logic [4:0]  InSrc1Addr, InSrc2Addr, InRdAddr, WbRdAddr, IssRdAddr;
    logic        InSrc1Rdy, InSrc2Rdy, WbAble, FaluStall, IssValid, IssPredict;
    logic [63:0] InSrc1Data, InSrc2Data, WbRdData, IssSrc1Data, IssSrc2Data;

    int applied;
    int miscompares;

    typedef struct {
        logic        inv;
        logic [7:0]  op;
        logic [4:0]  s1a;
        logic        s1r;
        logic [63:0] s1d;
        logic [4:0]  s2a;
        logic        s2r;
        logic [63:0] s2d;
        logic        wb;
        logic [4:0]  wba;
        logic [63:0] wbd;
        logic        stall;
        logic        fl;
        logic [31:0] fcsr;
        logic        e_rdy;
        logic        e_iv;
        logic [7:0]  e_op;
        logic [63:0] e_s1;
        logic [63:0] e_s2;
        logic [31:0] e_fcsr;
    } vec_t;

    vec_t tv[$];

    fp_issue_queue dut (
        .Clk           (Clk),
        .Rest          (Rest),
        .Flush         (Flush),
        .InValid       (InValid),
        .InReady       (InReady),
        .InMicOp       (InMicOp),
        .InInstAddr    (InInstAddr),
        .InPredict     (InPredict),
        .InJumpOffset  (InJumpOffset),
        .InSrc1Addr    (InSrc1Addr),
        .InSrc1Rdy     (InSrc1Rdy),
        .InSrc1Data    (InSrc1Data),
        .InSrc2Addr    (InSrc2Addr),
        .InSrc2Rdy     (InSrc2Rdy),
        .InSrc2Data    (InSrc2Data),
        .InRdAddr      (InRdAddr),
        .WbAble        (WbAble),
        .WbRdAddr      (WbRdAddr),
        .WbRdData      (WbRdData),
        .FaluStall     (FaluStall),
        .Fcsr0Data     (Fcsr0Data),
        .IssValid      (IssValid),
        .IssMicOp      (IssMicOp),
        .IssInstAddr   (IssInstAddr),
        .IssPredict    (IssPredict),
        .IssJumpOffset (IssJumpOffset),
        .IssSrc1Data   (IssSrc1Data),
        .IssSrc2Data   (IssSrc2Data),
        .IssRdAddr     (IssRdAddr),
        .IssFcsr0      (IssFcsr0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(
        input logic inv, input logic [7:0] op,
        input logic [4:0] s1a, input logic s1r, input logic [63:0] s1d,
        input logic [4:0] s2a, input logic s2r, input logic [63:0] s2d,
        input logic wb, input logic [4:0] wba, input logic [63:0] wbd,
        input logic stall, input logic fl, input logic [31:0] fcsr,
        input logic e_rdy, input logic e_iv, input logic [7:0] e_op,
        input logic [63:0] e_s1, input logic [63:0] e_s2, input logic [31:0] e_fcsr
    );
        vec_t v;
        v.inv = inv; v.op = op; v.s1a = s1a; v.s1r = s1r; v.s1d = s1d;
        v.s2a = s2a; v.s2r = s2r; v.s2d = s2d; v.wb = wb; v.wba = wba; v.wbd = wbd;
        v.stall = stall; v.fl = fl; v.fcsr = fcsr; v.e_rdy = e_rdy; v.e_iv = e_iv;
        v.e_op = e_op; v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_fcsr = e_fcsr;
        return v;
    endfunction

    function automatic vec_t idle(
        input logic wb, input logic [4:0] wba, input logic [63:0] wbd,
        input logic stall, input logic [31:0] fcsr,
        input logic e_rdy, input logic e_iv, input logic [7:0] e_op,
        input logic [63:0] e_s1, input logic [63:0] e_s2, input logic [31:0] e_fcsr
    );
        return mk(N, 8'h00, 5'd0, N, Z, 5'd0, N, Z, wb, wba, wbd, stall, N, fcsr,
                  e_rdy, e_iv, e_op, e_s1, e_s2, e_fcsr);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
            miscompares++;
        end
    endtask

    task automatic drive(input vec_t v);
        InValid      = v.inv;
        InMicOp      = v.op;
        InInstAddr   = 32'h0000_1000 + {24'h0, v.op};
        InPredict    = v.op[0];
        InJumpOffset = {v.op, 24'h00_0040};
        InSrc1Addr   = v.s1a;
        InSrc1Rdy    = v.s1r;
        InSrc1Data   = v.s1d;
        InSrc2Addr   = v.s2a;
        InSrc2Rdy    = v.s2r;
        InSrc2Data   = v.s2d;
        InRdAddr     = v.op[4:0];
        WbAble       = v.wb;
        WbRdAddr     = v.wba;
        WbRdData     = v.wbd;
        FaluStall    = v.stall;
        Flush        = v.fl;
        Fcsr0Data    = v.fcsr;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        logic [31:0] e_pc;
        logic [31:0] e_off;
        e_pc  = 32'h0000_1000 + {24'h0, v.e_op};
        e_off = {v.e_op, 24'h00_0040};
        applied++;
        chk($sformatf("v%0d.InReady", k), 64'(InReady), 64'(v.e_rdy));
        chk($sformatf("v%0d.IssValid", k), 64'(IssValid), 64'(v.e_iv));
        if (v.e_iv) begin
            chk($sformatf("v%0d.IssMicOp", k), 64'(IssMicOp), 64'(v.e_op));
            chk($sformatf("v%0d.IssInstAddr", k), 64'(IssInstAddr), 64'(e_pc));
            chk($sformatf("v%0d.IssPredict", k), 64'(IssPredict), 64'(v.e_op[0]));
            chk($sformatf("v%0d.IssJumpOffset", k), 64'(IssJumpOffset), 64'(e_off));
            chk($sformatf("v%0d.IssSrc1Data", k), IssSrc1Data, v.e_s1);
            chk($sformatf("v%0d.IssSrc2Data", k), IssSrc2Data, v.e_s2);
            chk($sformatf("v%0d.IssRdAddr", k), 64'(IssRdAddr), 64'(v.e_op[4:0]));
            chk($sformatf("v%0d.IssFcsr0", k), 64'(IssFcsr0), 64'(v.e_fcsr));
        end
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        Rest        = 1'b0;
        drive(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h0, Z, Z, 32'h0));

        // Single dispatch with both operands present: issues two edges later.
        tv.push_back(mk(Y, 8'h10, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0000_00AA, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0055, Y, Y, 8'h10, F1, F2, 32'h0000_0055));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        // A waits on f3, younger B overtakes, broadcast wakes A.
        tv.push_back(mk(Y, 8'h21, 5'd3, N, Z, 5'd4, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h22, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(Y, 5'd3, F3, N, 32'h0000_0005, Y, Y, 8'h22, F1, F2, 32'h0000_0005));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0006, Y, Y, 8'h21, F3, F2, 32'h0000_0006));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        // Enqueue bypass: src2 f7 broadcast in the dispatch cycle.
        tv.push_back(mk(Y, 8'h30, 5'd1, Y, F1, 5'd7, N, Z, Y, 5'd7, F3, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0009, Y, Y, 8'h30, F1, F3, 32'h0000_0009));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        // Fill to full with f9 pending, wake all, dispatch while full is dropped, enqueue+issue together.
        tv.push_back(mk(Y, 8'h41, 5'd9, N, Z, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h42, 5'd9, N, Z, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h43, 5'd9, N, Z, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h44, 5'd9, N, Z, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, N, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(Y, 5'd9, F1, N, 32'h0, N, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h46, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0000_0016, Y, Y, 8'h41, F1, F2, 32'h0000_0016));
        tv.push_back(mk(Y, 8'h45, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0000_0017, Y, Y, 8'h42, F1, F2, 32'h0000_0017));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0018, Y, Y, 8'h43, F1, F2, 32'h0000_0018));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0019, Y, Y, 8'h44, F1, F2, 32'h0000_0019));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0020, Y, Y, 8'h45, F1, F2, 32'h0000_0020));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        // Three-cycle stall holds the slot, then issue resumes in age order.
        tv.push_back(mk(Y, 8'h51, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0000_0011, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h52, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0000_0022, Y, Y, 8'h51, F1, F2, 32'h0000_0022));
        tv.push_back(mk(Y, 8'h53, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, Y, N, 32'h0000_0033, Y, Y, 8'h51, F1, F2, 32'h0000_0022));
        tv.push_back(idle(N, 5'd0, Z, Y, 32'h0000_0044, Y, Y, 8'h51, F1, F2, 32'h0000_0022));
        tv.push_back(idle(N, 5'd0, Z, Y, 32'h0000_0045, Y, Y, 8'h51, F1, F2, 32'h0000_0022));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0055, Y, Y, 8'h52, F1, F2, 32'h0000_0055));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0066, Y, Y, 8'h53, F1, F2, 32'h0000_0066));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        // Flush with 3 entries, a valid slot, a dispatch and a broadcast all in the same cycle.
        tv.push_back(mk(Y, 8'h62, 5'd12, N, Z, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h63, 5'd12, N, Z, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h61, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0077, Y, Y, 8'h61, F1, F2, 32'h0000_0077));
        tv.push_back(mk(Y, 8'h65, 5'd12, N, Z, 5'd2, Y, F2, N, 5'd0, Z, Y, N, 32'h0, Y, Y, 8'h61, F1, F2, 32'h0000_0077));
        tv.push_back(mk(Y, 8'h66, 5'd1, Y, F1, 5'd2, Y, F2, Y, 5'd12, F3, N, Y, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(Y, 5'd12, F3, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(mk(Y, 8'h70, 5'd1, Y, F1, 5'd2, Y, F2, N, 5'd0, Z, N, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        tv.push_back(idle(N, 5'd0, Z, N, 32'h0000_0088, Y, Y, 8'h70, F1, F2, 32'h0000_0088));
        // Fill to full under stall so the slot keeps op 0x70 before the async reset.
        tv.push_back(mk(Y, 8'h81, 5'd20, N, Z, 5'd2, Y, F2, N, 5'd0, Z, Y, N, 32'h0, Y, Y, 8'h70, F1, F2, 32'h0000_0088));
        tv.push_back(mk(Y, 8'h82, 5'd20, N, Z, 5'd2, Y, F2, N, 5'd0, Z, Y, N, 32'h0, Y, Y, 8'h70, F1, F2, 32'h0000_0088));
        tv.push_back(mk(Y, 8'h83, 5'd20, N, Z, 5'd2, Y, F2, N, 5'd0, Z, Y, N, 32'h0, Y, Y, 8'h70, F1, F2, 32'h0000_0088));
        tv.push_back(mk(Y, 8'h84, 5'd20, N, Z, 5'd2, Y, F2, N, 5'd0, Z, Y, N, 32'h0, N, Y, 8'h70, F1, F2, 32'h0000_0088));

        // Reset state while held in reset.
        repeat (2) @(negedge Clk);
        applied++;
        chk("reset.InReady", 64'(InReady), 64'(1'b1));
        chk("reset.IssValid", 64'(IssValid), 64'(1'b0));
        chk("reset.IssMicOp", 64'(IssMicOp), 64'(8'h0));
        chk("reset.IssInstAddr", 64'(IssInstAddr), 64'(32'h0));
        chk("reset.IssSrc1Data", IssSrc1Data, Z);
        chk("reset.IssFcsr0", 64'(IssFcsr0), 64'(32'h0));
        Rest = 1'b1;

        for (int k = 0; k < tv.size(); k++) begin
            @(negedge Clk);
            drive(tv[k]);
            @(posedge Clk);
            #1;
            check_vec(k, tv[k]);
        end

        // Async reset mid-cycle, away from any clock edge.
        @(negedge Clk);
        drive(idle(N, 5'd0, Z, Y, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        #2;
        Rest = 1'b0;
        #1;
        applied++;
        chk("arst.InReady", 64'(InReady), 64'(1'b1));
        chk("arst.IssValid", 64'(IssValid), 64'(1'b0));
        chk("arst.IssMicOp", 64'(IssMicOp), 64'(8'h0));
        chk("arst.IssSrc1Data", IssSrc1Data, Z);
        chk("arst.IssFcsr0", 64'(IssFcsr0), 64'(32'h0));

        // Queue must really be empty: a broadcast for the old f20 entries issues nothing.
        @(negedge Clk);
        Rest = 1'b1;
        drive(idle(Y, 5'd20, F3, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        @(posedge Clk);
        #1;
        applied++;
        chk("post_arst0.IssValid", 64'(IssValid), 64'(1'b0));
        @(negedge Clk);
        drive(idle(N, 5'd0, Z, N, 32'h0, Y, N, 8'h00, Z, Z, 32'h0));
        @(posedge Clk);
        #1;
        applied++;
        chk("post_arst1.IssValid", 64'(IssValid), 64'(1'b0));
        chk("post_arst1.InReady", 64'(InReady), 64'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_issue_queue.md
# fp_issue_queue

In-order-aged issue queue for the floating-point pipe, sitting directly upstream of the FP ALU. Holds dispatched FP micro-ops until both source operands are present, captures operands from the writeback broadcast, and issues the oldest ready entry into a registered issue slot that drives the FP ALU inputs. It also supplies the FCSR0 value and the branch-check fields the ALU consumes.

## Interface
- `DEPTH`, 4, queue entries (2..8)
- `WIDTH_FALU`, 32, FP word width; operands are `2*WIDTH_FALU`
- `MICOP_W`, 8, micro-op code width (`MicOperateCode`)
- `ADDR_W`, 32, instruction address width (`InstAddrBus`)
- `AREG_W`, 5, architectural FP register index width (`ArchRegBUs`)

- `Clk`  in  1  clock, rising edge
- `Rest`  in  1  reset, asynchronous, active-low
- `Flush`  in  1  pipeline flush (mispredict/exception)
- `InValid`  in  1  dispatch request
- `InReady`  out  1  queue can accept (`count != DEPTH`)
- `InMicOp`  in  MICOP_W  micro-op
- `InInstAddr`  in  ADDR_W  instruction PC
- `InPredict`  in  1  predicted-taken bit
- `InJumpOffset`  in  WIDTH_FALU  branch offset
- `InSrc{1,2}Addr`  in  AREG_W  source register
- `InSrc{1,2}Rdy`  in  1  source value already valid
- `InSrc{1,2}Data`  in  2*WIDTH_FALU  source value (meaningful when Rdy)
- `InRdAddr`  in  AREG_W  destination register
- `WbAble`  in  1  writeback broadcast valid
- `WbRdAddr`  in  AREG_W  broadcast register
- `WbRdData`  in  2*WIDTH_FALU  broadcast value
- `FaluStall`  in  1  ALU cannot take a new op
- `Fcsr0Data`  in  WIDTH_FALU  current FCSR0
- `IssValid`  out  1  issue slot valid
- `IssMicOp`, `IssInstAddr`, `IssPredict`, `IssJumpOffset`, `IssSrc1Data`, `IssSrc2Data`, `IssRdAddr`, `IssFcsr0`  out  widths as inputs  issue-slot fields

## Operation
- Storage: DEPTH entries, compacting; index 0 oldest, valid entries contiguous in `[0, count)`.
- Enqueue when `InValid & InReady & !Flush`: entry written at `count`, or `count-1` if an issue occurs in the same cycle.
- Enqueue bypass: if `WbAble` and `WbRdAddr == InSrcNAddr` and `!InSrcNRdy`, entry stores `WbRdData` with Rdy=1.
- Wakeup: each valid entry whose not-ready source matches `WbRdAddr` while `WbAble` captures data and sets Rdy. Wakeup and shift apply in the same edge (data follows the shifted entry).
- Select: lowest index valid entry with both Rdy set, using state at cycle start (no same-cycle wakeup→select).
- Issue when `!FaluStall` and a ready entry exists: entry copied to issue slot, `Fcsr0Data` sampled into `IssFcsr0`, entries above shift down one, `count` decrements.
- `!FaluStall` and no ready entry: `IssValid` ← 0. `FaluStall`: issue slot and queue selection frozen (enqueue/wakeup continue).
- Enqueue + issue same cycle: count unchanged. Full queue: `InReady=0` even if an issue is pending.
- Flush: next edge `count` ← 0, `IssValid` ← 0; same-cycle enqueue and wakeup dropped. Flush dominates everything.
- Register 0 is not special; matching is plain index compare.

## Timing
- Reset: `count`=0, all entry valid/Rdy=0, `IssValid`=0, all `Iss*` fields 0, `InReady`=1.
- Reset asserted mid-operation clears state immediately (async), regardless of `Clk`.
- Latency: dispatch with both ready at edge N → in queue after N, `IssValid`=1 after edge N+1 (2 cycles dispatch-to-ALU input).
- Wakeup at edge N → selectable in cycle after N → issued at edge N+1.
- Throughput: one issue per cycle when unstalled.
- `InReady` is combinational from `count` only; no path from `InValid` or `FaluStall`.

## Structure
- Shared package: `MicOperateCode`/`InstAddrBus`/`ArchRegBUs` widths, FP zero constant, entry struct (valid, micop, pc, predict, offset, src addr/rdy/data ×2, rd).
- Sub-module `fp_iq_select`: combinational oldest-ready priority encoder, outputs `SelValid`, `SelIdx`.

## Test plan
- Dispatch `InMicOp=0x10`, both Rdy, Src1=0x3F800000, Src2=0x40000000 -> two edges later `IssValid=1`, data matches, `IssFcsr0`=sampled FCSR0.
- Dispatch A (Src1 f3 not ready), then B ready -> B issues first; `WbAble` f3=0x40400000 -> A issues next cycle+1 with Src1=0x40400000.
- Dispatch with `InSrc2Addr=7` not ready while `WbRdAddr=7`, `WbAble=1` -> entry enters ready, issues two edges later.
- Fill 4 entries, none ready -> `InReady=0`; wakeup all with one broadcast -> issue order 0,1,2,3 on consecutive cycles, `InReady`=1 after first issue.
- `FaluStall=1` for 3 cycles with ready entries -> `Iss*` hold, count unchanged; release -> resume in age order.
- Flush with 3 entries and `IssValid=1` plus simultaneous `InValid` -> next cycle `count=0`, `IssValid=0`, `InReady=1`; async `Rest` low mid-cycle clears immediately.
